// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DIN[0]..DIN[7] LSB first, optional even parity, stop bit.
// Every bit holds SOUT for DIV clock cycles; one word is accepted per frame.
module serial_tx #(
  parameter int unsigned DIV       = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [7:0] DIN,
  input  logic       LOAD,
  output logic       READY,
  output logic       SOUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Value loaded into the bit-time down-counter at the start of every bit.
  localparam logic [15:0] BIT_RELOAD = 16'(DIV - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        sout_q;
  logic        busy_q;
  logic        done_q;

  logic        bit_end_d;
  logic [15:0] cnt_d;

  // The last cycle of a bit is the one where the counter has reached zero.
  assign bit_end_d = (cnt_q == 16'd0);
  assign cnt_d     = bit_end_d ? BIT_RELOAD : cnt_q - 16'd1;

  // NOTE: the reset branch lives inside the clocked block, so R dropping between
  // edges never disturbs the outputs; all state updates here use <= so every
  // register sees the values from before this edge.
  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (LOAD) begin
            shift_q <= DIN;
            par_q   <= ^DIN;
            cnt_q   <= BIT_RELOAD;
            idx_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end

        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end_d) begin
            sout_q  <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end_d) begin
            if (idx_q == 3'd7) begin
              idx_q <= '0;
              if (PARITY_EN) begin
                sout_q  <= par_q;
                state_q <= S_PARITY;
              end else begin
                sout_q  <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              idx_q   <= idx_q + 3'd1;
              sout_q  <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end

        S_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end_d) begin
            sout_q  <= 1'b1;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end_d) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        default: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign SOUT  = sout_q;
  assign BUSY  = busy_q;
  assign READY = ~busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parameterisations share one stimulus stream and are
// compared every cycle against a frame-table model, plus hand-derived waveforms.
module tb_serial_tx;

  localparam int N = 3;

  logic       CLK = 1'b0;
  logic       R;
  logic       LOAD;
  logic [7:0] DIN;

  logic [N-1:0] ready;
  logic [N-1:0] sout;
  logic [N-1:0] busy;
  logic [N-1:0] done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  serial_tx #(.DIV(4), .PARITY_EN(1'b1)) u_d4p1 (
    .CLK(CLK), .R(R), .DIN(DIN), .LOAD(LOAD),
    .READY(ready[0]), .SOUT(sout[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  serial_tx #(.DIV(4), .PARITY_EN(1'b0)) u_d4p0 (
    .CLK(CLK), .R(R), .DIN(DIN), .LOAD(LOAD),
    .READY(ready[1]), .SOUT(sout[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  serial_tx #(.DIV(1), .PARITY_EN(1'b1)) u_d1p1 (
    .CLK(CLK), .R(R), .DIN(DIN), .LOAD(LOAD),
    .READY(ready[2]), .SOUT(sout[2]), .BUSY(busy[2]), .DONE(done[2])
  );

  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit par_of(input int i);
    return (i != 1);
  endfunction

  function automatic int frame_len(input int i);
    return (10 + int'(par_of(i))) * div_of(i);
  endfunction

  // Line levels of a whole frame, bit 0 first; unused upper positions stay 1.
  function automatic logic [10:0] build_frame(input logic [7:0] d, input bit p);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (p) f[9] = ^d;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a table of line levels indexed by elapsed_cycles / DIV.
  bit          m_active [N];
  int          m_e      [N];
  bit          m_done   [N];
  logic [10:0] m_frame  [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_e[i]      = 0;
      m_done[i]   = 1'b0;
      m_frame[i]  = '1;
    end
  end

  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (R !== 1'b1) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
        m_e[i]      = 0;
      end else if (m_active[i]) begin
        m_e[i] = m_e[i] + 1;
        if (m_e[i] == frame_len(i)) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (LOAD) begin
          m_active[i] = 1'b1;
          m_e[i]      = 0;
          m_frame[i]  = build_frame(DIN, par_of(i));
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        logic exp_sout;
        exp_sout = m_active[i] ? m_frame[i][m_e[i] / div_of(i)] : 1'b1;
        check($sformatf("u%0d.sout", i), 32'(sout[i]), 32'(exp_sout));
        check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_active[i]));
        check($sformatf("u%0d.ready", i), 32'(ready[i]), 32'(!m_active[i]));
        check($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_done[i] && !m_active[i]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    R    = 1'b0;
    LOAD = 1'b0;
    next_cycle();
    R = 1'b1;
  endtask

  // Accepts d on the next edge; returns #1 after that edge (start of cycle 1).
  task automatic accept(input logic [7:0] d);
    LOAD = 1'b1;
    DIN  = d;
    next_cycle();
    LOAD = 1'b0;
    DIN  = 8'($urandom);
  endtask

  int seq_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int seq_55 [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
  int seq_0f [11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    R    = 1'b0;
    LOAD = 1'b0;
    DIN  = 8'h00;
    repeat (3) next_cycle();
    R = 1'b1;
    @(negedge CLK);
    chk_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst.sout%0d", i), 32'(sout[i]), 32'd1);
      check($sformatf("rst.ready%0d", i), 32'(ready[i]), 32'd1);
      check($sformatf("rst.busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst.done%0d", i), 32'(done[i]), 32'd0);
    end
    next_cycle();

    // 0xA5, DIV=4, parity on; a 0xFF load in cycle 10 must be ignored.
    do_reset();
    accept(8'hA5);
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        LOAD = 1'b1;
        DIN  = 8'hFF;
      end else begin
        LOAD = 1'b0;
        DIN  = 8'($urandom);
      end
      @(negedge CLK);
      if (k <= 44) begin
        check($sformatf("a5.sout.c%0d", k), 32'(sout[0]), 32'(seq_a5[(k - 1) / 4]));
        check($sformatf("a5.ready.c%0d", k), 32'(ready[0]), 32'd0);
      end
      if (k == 44) check("a5.done_early", 32'(done[0]), 32'd0);
      if (k == 45) begin
        check("a5.done", 32'(done[0]), 32'd1);
        check("a5.ready_end", 32'(ready[0]), 32'd1);
      end
      next_cycle();
    end

    // 0x07: parity bit 1 with parity on; 40-cycle frame with parity off.
    do_reset();
    accept(8'h07);
    for (int k = 1; k <= 41; k++) begin
      @(negedge CLK);
      if (k >= 37 && k <= 40) begin
        check("07.parity", 32'(sout[0]), 32'd1);
        check("07.stop_np", 32'(sout[1]), 32'd1);
      end
      if (k == 40) check("07.busy_np", 32'(busy[1]), 32'd1);
      if (k == 41) begin
        check("07.done_np", 32'(done[1]), 32'd1);
        check("07.busy_p", 32'(busy[0]), 32'd1);
      end
      next_cycle();
    end

    // 0x00 at DIV=1: ten zero cycles, one stop cycle, DONE in cycle 12.
    do_reset();
    accept(8'h00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k <= 10) check($sformatf("00.zero.c%0d", k), 32'(sout[2]), 32'd0);
      if (k == 11) begin
        check("00.stop", 32'(sout[2]), 32'd1);
        check("00.done_early", 32'(done[2]), 32'd0);
      end
      if (k == 12) check("00.done", 32'(done[2]), 32'd1);
      next_cycle();
    end

    // Reset pulse during data bit 3 (cycles 17..20) of a 0xA5 frame at DIV=4.
    do_reset();
    accept(8'hA5);
    for (int k = 1; k <= 70; k++) begin
      R = (k != 18);
      @(negedge CLK);
      if (k == 18) check("abort.bit3", 32'(sout[0]), 32'd0);
      if (k == 19) begin
        check("abort.sout", 32'(sout[0]), 32'd1);
        check("abort.ready", 32'(ready[0]), 32'd1);
        check("abort.busy", 32'(busy[0]), 32'd0);
      end
      if (k >= 19) check($sformatf("abort.nodone.c%0d", k), 32'(done[0]), 32'd0);
      next_cycle();
    end

    // LOAD held at DIV=1: 0x55 then 0x0F with exactly one DONE cycle between.
    do_reset();
    LOAD = 1'b1;
    DIN  = 8'h55;
    next_cycle();
    DIN = 8'h0F;
    for (int k = 1; k <= 24; k++) begin
      LOAD = (k < 24);
      @(negedge CLK);
      if (k <= 11) check($sformatf("b2b.f1.c%0d", k), 32'(sout[2]), 32'(seq_55[k - 1]));
      if (k >= 13 && k <= 23) begin
        check($sformatf("b2b.f2.c%0d", k), 32'(sout[2]), 32'(seq_0f[k - 13]));
        check($sformatf("b2b.ready.c%0d", k), 32'(ready[2]), 32'd0);
        check($sformatf("b2b.done.c%0d", k), 32'(done[2]), 32'd0);
      end
      if (k == 11 || k == 13) check($sformatf("b2b.done1w.c%0d", k), 32'(done[2]), 32'd0);
      if (k == 12 || k == 24) begin
        check($sformatf("b2b.done.c%0d", k), 32'(done[2]), 32'd1);
        check($sformatf("b2b.idle.c%0d", k), 32'(ready[2]), 32'd1);
      end
      next_cycle();
    end

    // Random traffic, occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      LOAD = ($urandom_range(0, 3) == 0);
      DIN  = 8'($urandom);
      R    = ($urandom_range(0, 249) != 0);
      next_cycle();
    end
    R    = 1'b1;
    LOAD = 1'b0;
    repeat (60) next_cycle();

    @(negedge CLK);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
